// File: rtl/types_pkg.sv
// Shared types for the back end: checkpoint snapshot layout and the
// recovery sequencer's state encoding and field widths.
package types_pkg;

    localparam int ROB_TAG_W = 5;
    localparam int PREG_W    = 7;
    localparam int PREG_NUM  = 128;

    // Snapshot captured at branch dispatch and replayed on mispredict.
    typedef struct packed {
        logic                valid;
        logic [31:0]         pc;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [PREG_NUM-1:0] reset_reg_rdy_table;
    } checkpoint;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEAR    = 2'd1,
        WALK     = 2'd2,
        REDIRECT = 2'd3
    } recovery_state_t;

endpackage

// File: rtl/branch_recovery.sv
// Branch mispredict recovery sequencer. Flushes younger ops, clears ready
// bits from the checkpoint, walks the ROB youngest-first undoing renames and
// freeing pregs, truncates the ROB tail and finally redirects fetch.
module branch_recovery
    import types_pkg::*;
#(
    parameter int ROB_DEPTH  = 32,
    parameter int PREG_COUNT = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mispredict,
    input  logic [$clog2(ROB_DEPTH)-1:0]  mispredict_tag,
    input  logic [31:0]                   mispredict_target,
    input  logic                          checkpoint_valid,
    input  checkpoint                     snapshot,
    input  logic [$clog2(ROB_DEPTH)-1:0]  rob_tail,
    output logic [$clog2(ROB_DEPTH)-1:0]  rob_rd_idx,
    input  logic                          rob_rd_has_dest,
    input  logic [4:0]                    rob_rd_arch,
    input  logic [$clog2(PREG_COUNT)-1:0] rob_rd_pd_new,
    input  logic [$clog2(PREG_COUNT)-1:0] rob_rd_pd_old,
    output logic                          busy,
    output logic                          flush_valid,
    output logic [$clog2(ROB_DEPTH)-1:0]  flush_tag,
    output logic                          rdy_clear_valid,
    output logic [PREG_COUNT-1:0]         rdy_clear_mask,
    output logic                          map_restore_valid,
    output logic [4:0]                    map_restore_arch,
    output logic [$clog2(PREG_COUNT)-1:0] map_restore_preg,
    output logic                          free_valid,
    output logic [$clog2(PREG_COUNT)-1:0] free_preg,
    output logic                          rob_tail_restore_valid,
    output logic [$clog2(ROB_DEPTH)-1:0]  rob_tail_restore,
    output logic                          redirect_valid,
    output logic [31:0]                   redirect_pc,
    output logic                          recover_err
);

    localparam int TAG_W = $clog2(ROB_DEPTH);

    recovery_state_t     state;
    logic [TAG_W-1:0]    tag_q;
    logic [TAG_W-1:0]    walk_ptr;
    logic [TAG_W-1:0]    count;
    logic [31:0]         target_q;
    logic [PREG_COUNT-1:0] mask_q;

    // Only the ready table is consumed from the snapshot; tag and target
    // come directly from the resolving branch.
    logic unused_snapshot;
    assign unused_snapshot = ^{snapshot.valid, snapshot.pc, snapshot.rob_tag};

    // Recovery sequencer: latch branch context in IDLE, then step
    // CLEAR -> WALK (count entries) -> REDIRECT. Mispredicts outside IDLE are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tag_q       <= '0;
            walk_ptr    <= '0;
            count       <= '0;
            target_q    <= '0;
            mask_q      <= '0;
            recover_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        tag_q    <= mispredict_tag;
                        target_q <= mispredict_target;
                        mask_q   <= checkpoint_valid ? snapshot.reset_reg_rdy_table : '0;
                        walk_ptr <= rob_tail - TAG_W'(1);
                        count    <= rob_tail - mispredict_tag - TAG_W'(1);
                        if (!checkpoint_valid)
                            recover_err <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= (count == '0) ? REDIRECT : WALK;
                end
                WALK: begin
                    walk_ptr <= walk_ptr - TAG_W'(1);
                    count    <= count - TAG_W'(1);
                    // Last entry processed is the one at tag+1.
                    if (count == TAG_W'(1))
                        state <= REDIRECT;
                end
                REDIRECT: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from registered state; the only combinational inputs are
    // the async ROB read fields during WALK, never mispredict.
    always_comb begin
        busy                   = (state != IDLE);
        flush_valid            = (state == CLEAR);
        flush_tag              = tag_q;
        rdy_clear_valid        = (state == CLEAR);
        rdy_clear_mask         = (state == CLEAR) ? mask_q : '0;
        rob_rd_idx             = (state == WALK) ? walk_ptr : '0;
        map_restore_valid      = (state == WALK) && rob_rd_has_dest;
        map_restore_arch       = map_restore_valid ? rob_rd_arch : '0;
        map_restore_preg       = map_restore_valid ? rob_rd_pd_old : '0;
        free_valid             = map_restore_valid;
        free_preg              = map_restore_valid ? rob_rd_pd_new : '0;
        rob_tail_restore_valid = (state == REDIRECT);
        rob_tail_restore       = (state == REDIRECT) ? tag_q + TAG_W'(1) : '0;
        redirect_valid         = (state == REDIRECT);
        redirect_pc            = (state == REDIRECT) ? target_q : '0;
    end

endmodule

// File: tb/tb_branch_recovery.sv
// Directed bench for branch_recovery with a small ROB array model.
module tb_branch_recovery;
    import types_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         mispredict;
    logic [4:0]   mispredict_tag;
    logic [31:0]  mispredict_target;
    logic         checkpoint_valid;
    checkpoint    snapshot;
    logic [4:0]   rob_tail;
    logic [4:0]   rob_rd_idx;
    logic         rob_rd_has_dest;
    logic [4:0]   rob_rd_arch;
    logic [6:0]   rob_rd_pd_new;
    logic [6:0]   rob_rd_pd_old;
    logic         busy;
    logic         flush_valid;
    logic [4:0]   flush_tag;
    logic         rdy_clear_valid;
    logic [127:0] rdy_clear_mask;
    logic         map_restore_valid;
    logic [4:0]   map_restore_arch;
    logic [6:0]   map_restore_preg;
    logic         free_valid;
    logic [6:0]   free_preg;
    logic         rob_tail_restore_valid;
    logic [4:0]   rob_tail_restore;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         recover_err;

    int checks = 0;
    int failures = 0;

    logic       rob_hd [32];
    logic [4:0] rob_ar [32];
    logic [6:0] rob_po [32];
    logic [6:0] rob_pn [32];

    assign rob_rd_has_dest = rob_hd[rob_rd_idx];
    assign rob_rd_arch     = rob_ar[rob_rd_idx];
    assign rob_rd_pd_old   = rob_po[rob_rd_idx];
    assign rob_rd_pd_new   = rob_pn[rob_rd_idx];

    always #5 clk = ~clk;

    branch_recovery #(.ROB_DEPTH(32), .PREG_COUNT(128)) dut (
        .clk(clk), .reset(reset),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .mispredict_target(mispredict_target), .checkpoint_valid(checkpoint_valid),
        .snapshot(snapshot), .rob_tail(rob_tail), .rob_rd_idx(rob_rd_idx),
        .rob_rd_has_dest(rob_rd_has_dest), .rob_rd_arch(rob_rd_arch),
        .rob_rd_pd_new(rob_rd_pd_new), .rob_rd_pd_old(rob_rd_pd_old),
        .busy(busy), .flush_valid(flush_valid), .flush_tag(flush_tag),
        .rdy_clear_valid(rdy_clear_valid), .rdy_clear_mask(rdy_clear_mask),
        .map_restore_valid(map_restore_valid), .map_restore_arch(map_restore_arch),
        .map_restore_preg(map_restore_preg), .free_valid(free_valid), .free_preg(free_preg),
        .rob_tail_restore_valid(rob_tail_restore_valid), .rob_tail_restore(rob_tail_restore),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .recover_err(recover_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_walk(input string tag, input logic [4:0] idx, input logic v,
                            input logic [4:0] ar, input logic [6:0] po, input logic [6:0] pn);
        chk({tag, "_idx"}, 128'(rob_rd_idx), 128'(idx));
        chk({tag, "_mapv"}, 128'(map_restore_valid), 128'(v));
        chk({tag, "_freev"}, 128'(free_valid), 128'(v));
        if (v) begin
            chk({tag, "_arch"}, 128'(map_restore_arch), 128'(ar));
            chk({tag, "_pold"}, 128'(map_restore_preg), 128'(po));
            chk({tag, "_pnew"}, 128'(free_preg), 128'(pn));
        end
        chk({tag, "_redir0"}, 128'(redirect_valid), 128'(0));
    endtask

    task automatic start(input logic [4:0] tg, input logic [4:0] tl, input logic [31:0] pc,
                         input logic cv, input logic [127:0] m);
        mispredict        = 1'b1;
        mispredict_tag    = tg;
        rob_tail          = tl;
        mispredict_target = pc;
        checkpoint_valid  = cv;
        snapshot.valid    = cv;
        snapshot.reset_reg_rdy_table = m;
        tick();                         // now in cycle 1
        mispredict = 1'b0;
        mispredict_tag = 5'd0;
        mispredict_target = 32'd0;
        snapshot.reset_reg_rdy_table = '0;
    endtask

    logic [127:0] m4041;

    initial begin
        for (int i = 0; i < 32; i++) begin
            rob_hd[i] = 1'b0; rob_ar[i] = '0; rob_po[i] = '0; rob_pn[i] = '0;
        end
        reset = 1'b1;
        mispredict = 1'b0; mispredict_tag = '0; mispredict_target = '0;
        checkpoint_valid = 1'b0; snapshot = '0; rob_tail = '0;
        m4041 = '0;
        m4041[40] = 1'b1;
        m4041[41] = 1'b1;
        tick(); tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_redir", 128'(redirect_valid), 128'(0));
        chk("rst_err", 128'(recover_err), 128'(0));
        chk("rst_mask", rdy_clear_mask, 128'(0));
        reset = 1'b0;
        tick();

        // Test 1: tag 4, tail 8, three entries with destinations
        rob_hd[7] = 1; rob_ar[7] = 5'd1; rob_po[7] = 7'd10; rob_pn[7] = 7'd40;
        rob_hd[6] = 1; rob_ar[6] = 5'd2; rob_po[6] = 7'd11; rob_pn[6] = 7'd41;
        rob_hd[5] = 1; rob_ar[5] = 5'd3; rob_po[5] = 7'd12; rob_pn[5] = 7'd42;
        start(5'd4, 5'd8, 32'h0000_1000, 1'b1, m4041);
        chk("t1_c1_busy", 128'(busy), 128'(1));
        chk("t1_c1_flush", 128'(flush_valid), 128'(1));
        chk("t1_c1_ftag", 128'(flush_tag), 128'(4));
        chk("t1_c1_rdyv", 128'(rdy_clear_valid), 128'(1));
        chk("t1_c1_mask", rdy_clear_mask, m4041);
        chk("t1_c1_mapv", 128'(map_restore_valid), 128'(0));
        tick();
        chk("t1_c2_rdyv", 128'(rdy_clear_valid), 128'(0));
        chk("t1_c2_mask", rdy_clear_mask, 128'(0));
        chk("t1_c2_flush", 128'(flush_valid), 128'(0));
        chk_walk("t1_c2", 5'd7, 1'b1, 5'd1, 7'd10, 7'd40);
        tick(); chk_walk("t1_c3", 5'd6, 1'b1, 5'd2, 7'd11, 7'd41);
        tick(); chk_walk("t1_c4", 5'd5, 1'b1, 5'd3, 7'd12, 7'd42);
        tick();
        chk("t1_c5_redir", 128'(redirect_valid), 128'(1));
        chk("t1_c5_pc", 128'(redirect_pc), 128'(32'h0000_1000));
        chk("t1_c5_tailv", 128'(rob_tail_restore_valid), 128'(1));
        chk("t1_c5_tail", 128'(rob_tail_restore), 128'(5));
        chk("t1_c5_busy", 128'(busy), 128'(1));
        chk("t1_c5_mapv", 128'(map_restore_valid), 128'(0));
        tick();
        chk("t1_c6_busy", 128'(busy), 128'(0));
        chk("t1_c6_redir", 128'(redirect_valid), 128'(0));
        chk("t1_err", 128'(recover_err), 128'(0));

        // Test 2: wrap, tag 30, tail 2; entry 0 has no dest; mispredict during WALK ignored
        rob_hd[1]  = 1; rob_ar[1]  = 5'd7; rob_po[1]  = 7'd20; rob_pn[1]  = 7'd60;
        rob_hd[0]  = 0; rob_ar[0]  = 5'd8; rob_po[0]  = 7'd21; rob_pn[0]  = 7'd61;
        rob_hd[31] = 1; rob_ar[31] = 5'd9; rob_po[31] = 7'd22; rob_pn[31] = 7'd62;
        start(5'd30, 5'd2, 32'hABCD_0040, 1'b1, 128'(0));
        chk("t2_c1_ftag", 128'(flush_tag), 128'(30));
        tick(); chk_walk("t2_c2", 5'd1, 1'b1, 5'd7, 7'd20, 7'd60);
        mispredict = 1'b1; mispredict_tag = 5'd3; rob_tail = 5'd9;
        mispredict_target = 32'h5555_5555; checkpoint_valid = 1'b0;
        tick(); chk_walk("t2_c3", 5'd0, 1'b0, 5'd0, 7'd0, 7'd0);
        mispredict = 1'b0; checkpoint_valid = 1'b1;
        tick(); chk_walk("t2_c4", 5'd31, 1'b1, 5'd9, 7'd22, 7'd62);
        chk("t2_c4_ftag", 128'(flush_tag), 128'(30));
        tick();
        chk("t2_c5_redir", 128'(redirect_valid), 128'(1));
        chk("t2_c5_pc", 128'(redirect_pc), 128'(32'hABCD_0040));
        chk("t2_c5_tail", 128'(rob_tail_restore), 128'(31));
        tick();
        chk("t2_c6_busy", 128'(busy), 128'(0));
        tick();
        chk("t2_c7_busy", 128'(busy), 128'(0));
        chk("t2_err", 128'(recover_err), 128'(0));

        // Test 3: zero-length walk, tag 9, tail 10
        start(5'd9, 5'd10, 32'h0000_2000, 1'b1, m4041);
        chk("t3_c1_flush", 128'(flush_valid), 128'(1));
        chk("t3_c1_redir", 128'(redirect_valid), 128'(0));
        tick();
        chk("t3_c2_redir", 128'(redirect_valid), 128'(1));
        chk("t3_c2_tail", 128'(rob_tail_restore), 128'(10));
        chk("t3_c2_mapv", 128'(map_restore_valid), 128'(0));
        chk("t3_c2_freev", 128'(free_valid), 128'(0));
        tick();
        chk("t3_c3_busy", 128'(busy), 128'(0));

        // Test 4: no checkpoint -> empty mask, sticky error
        rob_hd[13] = 1; rob_ar[13] = 5'd4; rob_po[13] = 7'd30; rob_pn[13] = 7'd70;
        start(5'd12, 5'd14, 32'h0000_3000, 1'b0, m4041);
        chk("t4_c1_rdyv", 128'(rdy_clear_valid), 128'(1));
        chk("t4_c1_mask", rdy_clear_mask, 128'(0));
        chk("t4_c1_err", 128'(recover_err), 128'(1));
        tick(); chk_walk("t4_c2", 5'd13, 1'b1, 5'd4, 7'd30, 7'd70);
        tick();
        chk("t4_c3_redir", 128'(redirect_valid), 128'(1));
        tick(); tick();
        chk("t4_err_sticky", 128'(recover_err), 128'(1));

        // Test 5: reset during WALK, tag 0, tail 6
        for (int i = 1; i < 6; i++) begin
            rob_hd[i] = 1; rob_ar[i] = 5'(i); rob_po[i] = 7'(i + 80); rob_pn[i] = 7'(i + 100);
        end
        start(5'd0, 5'd6, 32'h0000_4000, 1'b1, m4041);
        tick(); chk_walk("t5_c2", 5'd5, 1'b1, 5'd5, 7'd85, 7'd105);
        reset = 1'b1;
        tick();
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_mapv", 128'(map_restore_valid), 128'(0));
        chk("t5_freev", 128'(free_valid), 128'(0));
        chk("t5_idx", 128'(rob_rd_idx), 128'(0));
        chk("t5_ftag", 128'(flush_tag), 128'(0));
        chk("t5_err", 128'(recover_err), 128'(0));
        chk("t5_redir", 128'(redirect_valid), 128'(0));
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_noredir", 128'(redirect_valid), 128'(0));
            chk("t5_idle", 128'(busy), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
